// File: rtl/serial_rx_pkg.sv
// rtl/serial_rx_pkg.sv - shared types and defaults for the serial word receiver
package serial_rx_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

    localparam int   DEFAULT_WIDTH        = 10;
    localparam int   DEFAULT_CLKS_PER_BIT = 16;
    localparam logic LINE_IDLE            = 1'b1;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous bit
module sync_2ff
    import serial_rx_pkg::*;
#(
    parameter logic RESET_VAL = LINE_IDLE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - start/data/stop serial receiver feeding a WIDTH-bit load register
module serial_word_rx
    import serial_rx_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rxd,
    output logic [WIDTH-1:0] D,
    output logic             load,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH + 1);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    logic rxd_s;

    rx_state_t        state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [WIDTH-1:0] sh, sh_d;
    logic [WIDTH-1:0] d_d;
    logic             load_d;
    logic             frame_err_d;

    sync_2ff #(
        .RESET_VAL (LINE_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            sh        <= '0;
            D         <= '0;
            load      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            idx       <= idx_d;
            sh        <= sh_d;
            D         <= d_d;
            load      <= load_d;
            frame_err <= frame_err_d;
        end
    end

    // Start bit is re-checked at its middle; every later sample lands one full bit later.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        idx_d       = idx;
        sh_d        = sh;
        d_d         = D;
        load_d      = 1'b0;
        frame_err_d = 1'b0;

        case (state)
            IDLE: begin
                if (rxd_s != LINE_IDLE) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end

            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_d = '0;
                    if (rxd_s != LINE_IDLE) begin
                        state_d = DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            DATA: begin
                if (cnt == BIT_LAST) begin
                    sh_d  = {rxd_s, sh[WIDTH-1:1]};
                    cnt_d = '0;
                    idx_d = idx + 1'b1;
                    if (idx == IDX_LAST) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_d = '0;
                    if (rxd_s == LINE_IDLE) begin
                        d_d     = sh;
                        load_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = RECOVER;
                    end
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end

            // A held-low line (break) must return high before a new start is hunted.
            RECOVER: begin
                if (rxd_s == LINE_IDLE) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial front-end that feeds the 10-bit load register stage. It receives an asynchronous serial line (one start bit, WIDTH data bits LSB first, one stop bit). Each completed, correctly framed word is presented on `D`, with a single-cycle `load` strobe, so the downstream register captures it directly. Frames with a bad stop bit are dropped and flagged.

## Interface
- `WIDTH`, 10: data bits per frame; equals the downstream register width.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be even and ≥4.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `D` output WIDTH: last correctly framed word; held between frames.
- `load` output 1: one-cycle strobe; `D` is valid and new in the same cycle.
- `frame_err` output 1: one-cycle strobe when the stop bit samples 0.

## Operation
- `rxd` passes through a 2-flop synchronizer. Synchronizer flops reset to 1. The synchronized output is `rxd_s`.
- Counters:
  - `cnt` is a cycle counter, width $clog2(CLKS_PER_BIT).
  - `idx` is a bit index, width $clog2(WIDTH+1).
  - `sh` is a WIDTH-bit shift register.
- FSM states: IDLE, START, DATA, STOP, RECOVER.
- IDLE:
  - If `rxd_s`==0, go to START with `cnt`=0.
  - Otherwise stay.
- START:
  - `cnt` increments each cycle.
  - At `cnt`==CLKS_PER_BIT/2−1:
    - If `rxd_s`==0, go to DATA with `cnt`=0 and `idx`=0.
    - If `rxd_s`==1 (glitch), return to IDLE with no output activity.
- DATA:
  - At `cnt`==CLKS_PER_BIT−1, sample `rxd_s` into `sh`.
  - Shift is right-shift, MSB-in, so the first bit received ends in `sh[0]`.
  - Then set `cnt`=0 and increment `idx`.
  - After the WIDTH-th sample, go to STOP.
- STOP: at `cnt`==CLKS_PER_BIT−1, sample `rxd_s`.
  - If 1: `D`<=`sh`, `load`<=1, go to IDLE.
  - If 0: `frame_err`<=1, `D` unchanged, go to RECOVER.
- RECOVER: wait for `rxd_s`==1, then go to IDLE. A line held low (break) never produces a spurious frame.
- `load` and `frame_err` are registered. They are never both high, and each is high for exactly one cycle per event.
- Reset values: state=IDLE, `cnt`=0, `idx`=0, `sh`=0, `D`=0, `load`=0, `frame_err`=0, synchronizer=1.

## Timing
- Let t0 be the rising edge at which the first synchronizer flop first captures `rxd`=0.
  - IDLE→START occurs at edge t0+2.
- `load` or `frame_err` is high in the cycle after edge t0+2+CLKS_PER_BIT/2+(WIDTH+1)·CLKS_PER_BIT.
  - With default parameters this is edge t0+186.
- Data bit k is sampled at edge t0+2+CLKS_PER_BIT/2+(k+1)·CLKS_PER_BIT, i.e. at the nominal mid-bit.
- Back-to-back frames:
  - After a good stop sample the FSM is in IDLE while the line is still high.
  - A start bit beginning at the nominal end of the stop bit is accepted without loss.
- `rst_n` low at any time, including mid-frame:
  - All registers return to reset values immediately.
  - No `load` is issued for the aborted frame.
  - Reception resumes on the first start bit seen after `rst_n` rises.
- Glitch rejection: a low pulse shorter than CLKS_PER_BIT/2 cycles (measured at `rxd_s`) yields no `load` and no `frame_err`.

## Structure
- Shared package `serial_rx_pkg`:
  - State enum: IDLE, START, DATA, STOP, RECOVER.
  - Default constants: WIDTH=10, CLKS_PER_BIT=16.
  - Idle-line level constant: 1.
- Sub-module `sync_2ff` (1-bit, reset value 1) implements the synchronizer. Everything else lives in `serial_word_rx`.
- `D`/`load` connect directly to the downstream register's `D`/`load` inputs.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation. Required: `D`=0, `load`=0, `frame_err`=0, and no activity for 400 cycles with `rxd`=1.
- Good frame: send 10'h2A5, LSB first, stop=1. Required: `load` is high for exactly 1 cycle at edge t0+186, `D`=10'h2A5, and `D` is held afterward.
- Glitch: drive `rxd` low for 4 cycles, then high. Required: no `load`, no `frame_err`, and a following frame 10'h001 is received correctly.
- Framing error: send 10'h3FF with stop=0 and hold `rxd` low for 50 more cycles, then send 10'h155. Required:
  - `frame_err` is a 1-cycle pulse and `D` stays at its prior value.
  - No frame is accepted while the line is low.
  - `D`=10'h155 with `load` after the second frame.
- Back-to-back: send 10'h155 then 10'h2AA with zero idle gap. Required: two `load` pulses exactly (WIDTH+2)·CLKS_PER_BIT=192 cycles apart, with `D` values in order.
- Reset mid-frame: assert `rst_n` low during data bit 5 of 10'h3C3. Required: no `load`, and the next complete frame 10'h0F0 loads correctly.
